alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Initiator side of the ALU interface. Accepts operation requests from the decode stage over a valid/ready handshake and drives the ALU's op/in1/in2/alu_enable. It holds the ALU for a fixed number of cycles, then captures the 2*WORD_SIZE result and returns it to the register-file writeback port. A MUL result returns as two beats: low word, then high word. Sits between decode and alu; it is the only driver of the ALU inputs.

Parameters:
WORD_SIZE, 16, operand and writeback word width.
ALU_LAT, 1, cycles alu_enable is held before alu_out is sampled (minimum 1).
TAG_W, 4, width of the destination-register tag carried with each request.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_op  input  4  ALU opcode (`ALU_* codes from parameters.vh)
req_a  input  WORD_SIZE  operand 1
req_b  input  WORD_SIZE  operand 2
req_tag  input  TAG_W  destination tag
alu_op  output  4  to alu op
alu_in1  output  WORD_SIZE  to alu in1
alu_in2  output  WORD_SIZE  to alu in2
alu_enable  output  1  to alu alu_enable
alu_out  input  2*WORD_SIZE  from alu out
wb_valid  output  1  writeback beat valid
wb_ready  input  1  writeback sink accepts beat
wb_data  output  WORD_SIZE  writeback word
wb_tag  output  TAG_W  tag of the request
wb_hi  output  1  beat carries the high word (MUL second beat only)
wb_err  output  1  request not executed (illegal op or divide by zero)
busy  output  1  state != IDLE
op_count  output  16  completed requests, wraps 0xFFFF->0x0000

Behaviour:
- Reset (rst==0 at posedge): state=IDLE. All outputs are 0 except req_ready=1. op_count=0. Latch counter=0. Reset takes effect in any state; any in-flight request is dropped with no wb beat.
- States: IDLE, ISSUE, WB_LO, WB_HI.
- IDLE: req_ready=1. On req_valid&&req_ready, latch op/a/b/tag into registers.
  - Legal op with no divide-by-zero: go to ISSUE and load counter=ALU_LAT-1.
  - Illegal op (not ADD/SUB/MUL/SLT/AND/OR/XOR/SHIFT/DIV): go directly to WB_LO with result=0 and err=1.
  - DIV with req_b==0: go directly to WB_LO with result low word={WORD_SIZE{1}} and err=1.
  - In both error cases alu_enable is never asserted.
- ISSUE: alu_enable=1. alu_op/alu_in1/alu_in2 are driven from the latched registers and held stable for the whole state.
  - Counter decrements each cycle.
  - In the cycle the counter is 0, alu_out is sampled into the result register and the state moves to WB_LO.
  - req_ready=0.
- alu_op/in1/in2 are 0 and alu_enable=0 in every state other than ISSUE.
- WB_LO: wb_valid=1, wb_data=result[WORD_SIZE-1:0], wb_tag=latched tag, wb_hi=0, wb_err=err flag.
  - Outputs stay stable while wb_ready=0.
  - On wb_ready: if op==MUL and err==0, go to WB_HI; otherwise increment op_count and go to IDLE.
- WB_HI: wb_valid=1, wb_data=result[2*WORD_SIZE-1:WORD_SIZE], wb_hi=1, same tag. On wb_ready, increment op_count and go to IDLE.
- Non-MUL ops return the low word only; the high half of alu_out is discarded.
- Throughput: a request is accepted at the earliest one cycle after the final wb beat handshakes (no overlap).
- Minimum latency from acceptance to first wb_valid: ALU_LAT+1 cycles (ALU_LAT=1 gives 2). Error requests take 1 cycle.
- req_valid while req_ready=0 is ignored; the requester must hold it.
- Simultaneous final wb handshake and req_valid: the request is not accepted that cycle because req_ready=0 outside IDLE.
- op_count counts error completions too.

Test Plan:
- ADD, a=0x7FFF, b=0x0001, tag=3, wb_ready=1 -> alu_enable high exactly 1 cycle; wb_valid 2 cycles after acceptance with wb_data=0x8000, wb_tag=3, wb_hi=0, wb_err=0; op_count=1.
- MUL, a=0x1234, b=0x0100 -> beat1 wb_data=0x3400 wb_hi=0, then beat2 wb_data=0x0012 wb_hi=1; op_count increments once, after beat2.
- DIV, a=100, b=7 -> wb_data=0x000E. Then DIV with a=5, b=0 -> alu_enable never asserted, wb_data=0xFFFF, wb_err=1 one cycle after acceptance.
- Backpressure: SUB, a=10, b=3, wb_ready held low 5 cycles -> wb_valid/wb_data=0x0007/wb_tag stable throughout, req_ready=0 and a second req_valid is not accepted; accepted only after the beat completes.
- Illegal op 4'hF -> wb_err=1, wb_data=0, no ALU issue. With ALU_LAT=3 and an AND request -> alu_enable high exactly 3 cycles with operands stable.
- Reset mid-WB_HI of a MUL -> next cycle state=IDLE, wb_valid=0, req_ready=1, op_count=0; no high beat is ever produced.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: takes decode requests, holds the ALU for ALU_LAT cycles and
// returns the captured result to writeback (MUL returns low word, then high word).
module alu_issue_ctrl #(
  parameter int WORD_SIZE = 16,
  parameter int ALU_LAT   = 1,
  parameter int TAG_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [3:0]             req_op,
  input  logic [WORD_SIZE-1:0]   req_a,
  input  logic [WORD_SIZE-1:0]   req_b,
  input  logic [TAG_W-1:0]       req_tag,
  output logic [3:0]             alu_op,
  output logic [WORD_SIZE-1:0]   alu_in1,
  output logic [WORD_SIZE-1:0]   alu_in2,
  output logic                   alu_enable,
  input  logic [2*WORD_SIZE-1:0] alu_out,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [WORD_SIZE-1:0]   wb_data,
  output logic [TAG_W-1:0]       wb_tag,
  output logic                   wb_hi,
  output logic                   wb_err,
  output logic                   busy,
  output logic [15:0]            op_count
);

  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_MUL   = 4'h2;
  localparam logic [3:0] ALU_SLT   = 4'h3;
  localparam logic [3:0] ALU_AND   = 4'h4;
  localparam logic [3:0] ALU_OR    = 4'h5;
  localparam logic [3:0] ALU_XOR   = 4'h6;
  localparam logic [3:0] ALU_SHIFT = 4'h7;
  localparam logic [3:0] ALU_DIV   = 4'h8;

  localparam int               CNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB_LO = 2'd2,
    WB_HI = 2'd3
  } state_t;

  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [3:0]           op_r;
  logic [TAG_W-1:0]     tag_r;
  logic                 err_r;
  logic [WORD_SIZE-1:0] res_hi_r;

  logic accept_s;
  logic legal_s;
  logic div_zero_s;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_MUL, ALU_SLT, ALU_AND,
      ALU_OR, ALU_XOR, ALU_SHIFT, ALU_DIV: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  // Request decode: handshake and the two conditions that bypass the ALU.
  always_comb begin
    accept_s   = req_valid && req_ready && (state_r == IDLE);
    legal_s    = is_legal_op(req_op);
    div_zero_s = (req_op == ALU_DIV) && (req_b == {WORD_SIZE{1'b0}});
  end

  // Issue/writeback sequencer; every output is a register updated on transitions.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      op_r       <= 4'h0;
      tag_r      <= {TAG_W{1'b0}};
      err_r      <= 1'b0;
      res_hi_r   <= {WORD_SIZE{1'b0}};
      req_ready  <= 1'b1;
      alu_op     <= 4'h0;
      alu_in1    <= {WORD_SIZE{1'b0}};
      alu_in2    <= {WORD_SIZE{1'b0}};
      alu_enable <= 1'b0;
      wb_valid   <= 1'b0;
      wb_data    <= {WORD_SIZE{1'b0}};
      wb_tag     <= {TAG_W{1'b0}};
      wb_hi      <= 1'b0;
      wb_err     <= 1'b0;
      busy       <= 1'b0;
      op_count   <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r      <= req_op;
            tag_r     <= req_tag;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (legal_s && !div_zero_s) begin
              state_r    <= ISSUE;
              cnt_r      <= CNT_LOAD;
              err_r      <= 1'b0;
              alu_enable <= 1'b1;
              alu_op     <= req_op;
              alu_in1    <= req_a;
              alu_in2    <= req_b;
            end else begin
              // Error requests never touch the ALU; illegal ops report 0, divide by zero all ones.
              state_r  <= WB_LO;
              err_r    <= 1'b1;
              res_hi_r <= {WORD_SIZE{1'b0}};
              wb_valid <= 1'b1;
              wb_data  <= legal_s ? {WORD_SIZE{1'b1}} : {WORD_SIZE{1'b0}};
              wb_tag   <= req_tag;
              wb_hi    <= 1'b0;
              wb_err   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r    <= WB_LO;
            res_hi_r   <= alu_out[2*WORD_SIZE-1:WORD_SIZE];
            alu_enable <= 1'b0;
            alu_op     <= 4'h0;
            alu_in1    <= {WORD_SIZE{1'b0}};
            alu_in2    <= {WORD_SIZE{1'b0}};
            wb_valid   <= 1'b1;
            wb_data    <= alu_out[WORD_SIZE-1:0];
            wb_tag     <= tag_r;
            wb_hi      <= 1'b0;
            wb_err     <= 1'b0;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        WB_LO: begin
          if (wb_ready) begin
            if ((op_r == ALU_MUL) && !err_r) begin
              state_r <= WB_HI;
              wb_data <= res_hi_r;
              wb_hi   <= 1'b1;
            end else begin
              state_r   <= IDLE;
              req_ready <= 1'b1;
              busy      <= 1'b0;
              wb_valid  <= 1'b0;
              wb_data   <= {WORD_SIZE{1'b0}};
              wb_tag    <= {TAG_W{1'b0}};
              wb_hi     <= 1'b0;
              wb_err    <= 1'b0;
              op_count  <= op_count + 16'h0001;
            end
          end
        end
        WB_HI: begin
          if (wb_ready) begin
            state_r   <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            wb_valid  <= 1'b0;
            wb_data   <= {WORD_SIZE{1'b0}};
            wb_tag    <= {TAG_W{1'b0}};
            wb_hi     <= 1'b0;
            wb_err    <= 1'b0;
            op_count  <= op_count + 16'h0001;
          end
        end
        default: begin
          state_r    <= IDLE;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
          alu_enable <= 1'b0;
          alu_op     <= 4'h0;
          alu_in1    <= {WORD_SIZE{1'b0}};
          alu_in2    <= {WORD_SIZE{1'b0}};
          wb_valid   <= 1'b0;
          wb_data    <= {WORD_SIZE{1'b0}};
          wb_tag     <= {TAG_W{1'b0}};
          wb_hi      <= 1'b0;
          wb_err     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (ALU_LAT 1 and 3), a timestamp-based
// transaction model checked every cycle, directed cases pinned with literal values.
module tb_alu_issue_ctrl;
  localparam int W    = 16;
  localparam int TW   = 4;
  localparam int NI   = 2;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_SLT = 4'h3,
                         OP_AND = 4'h4, OP_OR = 4'h5, OP_XOR = 4'h6, OP_SHIFT = 4'h7,
                         OP_DIV = 4'h8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            req_valid [NI];
  logic            req_ready [NI];
  logic [3:0]      req_op    [NI];
  logic [W-1:0]    req_a     [NI];
  logic [W-1:0]    req_b     [NI];
  logic [TW-1:0]   req_tag   [NI];
  logic [3:0]      alu_op    [NI];
  logic [W-1:0]    alu_in1   [NI];
  logic [W-1:0]    alu_in2   [NI];
  logic            alu_enable[NI];
  logic [2*W-1:0]  alu_out   [NI];
  logic            wb_valid  [NI];
  logic            wb_ready  [NI];
  logic [W-1:0]    wb_data   [NI];
  logic [TW-1:0]   wb_tag    [NI];
  logic            wb_hi     [NI];
  logic            wb_err    [NI];
  logic            busy      [NI];
  logic [15:0]     op_count  [NI];
  logic [2*W-1:0]  junk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model state per instance, expressed as acceptance timestamps and a beat list.
  bit           m_known [NI];
  bit           m_busy  [NI];
  bit           m_clean [NI];
  bit           m_issue [NI];
  int           m_acc   [NI];
  int           m_wb_start [NI];
  logic [3:0]   m_op    [NI];
  logic [W-1:0] m_a     [NI];
  logic [W-1:0] m_b     [NI];
  logic [TW-1:0] m_tag  [NI];
  logic [W-1:0] m_bdata [NI][2];
  bit           m_bhi   [NI][2];
  bit           m_berr  [NI][2];
  int           m_nbeats[NI];
  int           m_bidx  [NI];
  logic [15:0]  m_count [NI];
  bit           pend    [NI];

  function automatic logic [2*W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [2*W-1:0] r;
    case (op)
      OP_ADD:   r = {{W{1'b0}}, a} + {{W{1'b0}}, b};
      OP_SUB:   r = {{W{1'b0}}, a - b};
      OP_MUL:   r = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      OP_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_AND:   r = {{W{1'b0}}, a & b};
      OP_OR:    r = {{W{1'b0}}, a | b};
      OP_XOR:   r = {{W{1'b0}}, a ^ b};
      OP_SHIFT: r = {{W{1'b0}}, a << b[3:0]};
      OP_DIV:   r = (b == 16'd0) ? 32'hFFFF_FFFF : {a % b, a / b};
      default:  r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  always @(posedge clk) junk <= (2*W)'($urandom);

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    alu_issue_ctrl #(.WORD_SIZE(W), .ALU_LAT((gi == 0) ? LAT0 : LAT1), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[gi]), .req_ready(req_ready[gi]), .req_op(req_op[gi]),
      .req_a(req_a[gi]), .req_b(req_b[gi]), .req_tag(req_tag[gi]),
      .alu_op(alu_op[gi]), .alu_in1(alu_in1[gi]), .alu_in2(alu_in2[gi]),
      .alu_enable(alu_enable[gi]), .alu_out(alu_out[gi]),
      .wb_valid(wb_valid[gi]), .wb_ready(wb_ready[gi]), .wb_data(wb_data[gi]),
      .wb_tag(wb_tag[gi]), .wb_hi(wb_hi[gi]), .wb_err(wb_err[gi]),
      .busy(busy[gi]), .op_count(op_count[gi])
    );
    assign alu_out[gi] = alu_enable[gi] ? alu_ref(alu_op[gi], alu_in1[gi], alu_in2[gi]) : junk;
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] cyc=%0d actual=0x%0h required=0x%0h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic model_accept(input int i);
    logic [2*W-1:0] r;
    bit legal, dz;
    legal = (req_op[i] <= OP_DIV);
    dz    = (req_op[i] == OP_DIV) && (req_b[i] == 16'd0);
    r     = alu_ref(req_op[i], req_a[i], req_b[i]);
    m_busy[i]  = 1'b1;
    m_clean[i] = 1'b0;
    m_acc[i]   = cyc + 1;
    m_op[i]    = req_op[i];
    m_a[i]     = req_a[i];
    m_b[i]     = req_b[i];
    m_tag[i]   = req_tag[i];
    m_issue[i] = legal && !dz;
    m_bidx[i]  = 0;
    m_nbeats[i] = 1;
    m_bhi[i][0] = 1'b0;
    m_berr[i][0] = !m_issue[i];
    if (!legal)      m_bdata[i][0] = 16'h0000;
    else if (dz)     m_bdata[i][0] = 16'hFFFF;
    else             m_bdata[i][0] = r[W-1:0];
    if (m_issue[i] && req_op[i] == OP_MUL) begin
      m_nbeats[i] = 2;
      m_bdata[i][1] = r[2*W-1:W];
      m_bhi[i][1] = 1'b1;
      m_berr[i][1] = 1'b0;
    end
    m_wb_start[i] = m_acc[i] + (m_issue[i] ? lat_of(i) : 0);
  endtask

  // Compare current outputs with the model, then advance the model by this cycle's inputs.
  task automatic model_cycle(input int i);
    logic en_x, wbv_x;
    if (m_known[i]) begin
      en_x  = m_busy[i] && m_issue[i] && (cyc < m_acc[i] + lat_of(i));
      wbv_x = m_busy[i] && (cyc >= m_wb_start[i]);
      chk("req_ready", i, req_ready[i], !m_busy[i]);
      chk("busy", i, busy[i], m_busy[i]);
      chk("alu_enable", i, alu_enable[i], en_x);
      chk("alu_op", i, alu_op[i], en_x ? m_op[i] : 4'h0);
      chk("alu_in1", i, alu_in1[i], en_x ? m_a[i] : 16'h0);
      chk("alu_in2", i, alu_in2[i], en_x ? m_b[i] : 16'h0);
      chk("wb_valid", i, wb_valid[i], wbv_x);
      chk("op_count", i, op_count[i], m_count[i]);
      if (wbv_x) begin
        chk("wb_data", i, wb_data[i], m_bdata[i][m_bidx[i]]);
        chk("wb_hi", i, wb_hi[i], m_bhi[i][m_bidx[i]]);
        chk("wb_err", i, wb_err[i], m_berr[i][m_bidx[i]]);
        chk("wb_tag", i, wb_tag[i], m_tag[i]);
      end else if (m_clean[i]) begin
        chk("wb_data_rst", i, wb_data[i], 16'h0);
        chk("wb_tag_rst", i, wb_tag[i], 4'h0);
        chk("wb_hi_rst", i, wb_hi[i], 1'b0);
        chk("wb_err_rst", i, wb_err[i], 1'b0);
      end
    end
    if (rst == 1'b0) begin
      m_known[i] = 1'b1;
      m_busy[i]  = 1'b0;
      m_clean[i] = 1'b1;
      m_count[i] = 16'h0;
    end else if (m_known[i]) begin
      if (m_busy[i]) begin
        if (cyc >= m_wb_start[i] && wb_ready[i]) begin
          m_bidx[i]++;
          if (m_bidx[i] == m_nbeats[i]) begin
            m_busy[i]  = 1'b0;
            m_count[i] = m_count[i] + 16'h1;
          end
        end
      end else if (req_valid[i]) begin
        model_accept(i);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NI; i++) model_cycle(i);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] tag);
    bit done;
    done = 1'b0;
    req_valid[i] = 1'b1;
    req_op[i] = op; req_a[i] = a; req_b[i] = b; req_tag[i] = tag;
    for (int n = 0; n < 40 && !done; n++) begin
      done = (req_ready[i] === 1'b1);
      step();
    end
    req_valid[i] = 1'b0;
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL issue[%0d] not accepted within 40 cycles", i);
    end
  endtask

  task automatic wait_wb(input int i);
    int n;
    n = 0;
    while (wb_valid[i] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (wb_valid[i] !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL wait_wb[%0d] no writeback within 20 cycles", i);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      req_valid[i] = 1'b0; req_op[i] = 4'h0; req_a[i] = 16'h0; req_b[i] = 16'h0;
      req_tag[i] = 4'h0; wb_ready[i] = 1'b1;
      m_known[i] = 1'b0; m_busy[i] = 1'b0; m_count[i] = 16'h0; m_clean[i] = 1'b0;
      pend[i] = 1'b0;
    end
    step();
    step();
    for (int i = 0; i < NI; i++) begin
      chk("rst_req_ready", i, req_ready[i], 1'b1);
      chk("rst_wb_valid", i, wb_valid[i], 1'b0);
      chk("rst_op_count", i, op_count[i], 16'h0);
      chk("rst_alu_enable", i, alu_enable[i], 1'b0);
      chk("rst_busy", i, busy[i], 1'b0);
    end
    rst = 1'b1;
    step();

    // ADD: one ALU cycle, result two cycles after acceptance.
    issue(0, OP_ADD, 16'h7FFF, 16'h0001, 4'd3);
    chk("add_en", 0, alu_enable[0], 1'b1);
    step();
    chk("add_valid", 0, wb_valid[0], 1'b1);
    chk("add_data", 0, wb_data[0], 16'h8000);
    chk("add_tag", 0, wb_tag[0], 4'd3);
    chk("add_err", 0, wb_err[0], 1'b0);
    step();
    chk("add_count", 0, op_count[0], 16'd1);

    // MUL: low beat then high beat, counted once.
    issue(0, OP_MUL, 16'h1234, 16'h0100, 4'd4);
    wait_wb(0);
    chk("mul_lo", 0, wb_data[0], 16'h3400);
    chk("mul_lo_hi", 0, wb_hi[0], 1'b0);
    step();
    chk("mul_hi", 0, wb_data[0], 16'h0012);
    chk("mul_hi_hi", 0, wb_hi[0], 1'b1);
    chk("mul_mid_count", 0, op_count[0], 16'd1);
    step();
    chk("mul_count", 0, op_count[0], 16'd2);

    // DIV, then divide by zero which bypasses the ALU.
    issue(0, OP_DIV, 16'd100, 16'd7, 4'd1);
    wait_wb(0);
    chk("div_data", 0, wb_data[0], 16'h000E);
    step();
    issue(0, OP_DIV, 16'd5, 16'd0, 4'd2);
    chk("dz_valid", 0, wb_valid[0], 1'b1);
    chk("dz_data", 0, wb_data[0], 16'hFFFF);
    chk("dz_err", 0, wb_err[0], 1'b1);
    chk("dz_en", 0, alu_enable[0], 1'b0);
    step();

    // Backpressure with a second request waiting.
    wb_ready[0] = 1'b0;
    issue(0, OP_SUB, 16'd10, 16'd3, 4'd5);
    wait_wb(0);
    req_valid[0] = 1'b1; req_op[0] = OP_ADD; req_a[0] = 16'd1; req_b[0] = 16'd1; req_tag[0] = 4'd6;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 0, wb_valid[0], 1'b1);
      chk("bp_data", 0, wb_data[0], 16'h0007);
      chk("bp_tag", 0, wb_tag[0], 4'd5);
      chk("bp_ready", 0, req_ready[0], 1'b0);
      step();
    end
    wb_ready[0] = 1'b1;
    step();
    chk("bp_idle", 0, req_ready[0], 1'b1);
    issue(0, OP_ADD, 16'd1, 16'd1, 4'd6);
    wait_wb(0);
    chk("bp2_data", 0, wb_data[0], 16'h0002);
    chk("bp2_tag", 0, wb_tag[0], 4'd6);
    step();

    // Illegal opcode.
    issue(0, 4'hF, 16'd1, 16'd2, 4'd7);
    chk("ill_valid", 0, wb_valid[0], 1'b1);
    chk("ill_err", 0, wb_err[0], 1'b1);
    chk("ill_data", 0, wb_data[0], 16'h0000);
    chk("ill_en", 0, alu_enable[0], 1'b0);
    step();

    // ALU_LAT=3 instance: enable held three cycles with stable operands.
    issue(1, OP_AND, 16'hF0F0, 16'h3C3C, 4'd9);
    for (int k = 0; k < 3; k++) begin
      chk("lat3_en", 1, alu_enable[1], 1'b1);
      chk("lat3_in1", 1, alu_in1[1], 16'hF0F0);
      chk("lat3_in2", 1, alu_in2[1], 16'h3C3C);
      step();
    end
    chk("lat3_en_off", 1, alu_enable[1], 1'b0);
    chk("lat3_data", 1, wb_data[1], 16'h3030);
    step();

    // Reset while the MUL high beat is pending.
    issue(0, OP_MUL, 16'hFFFF, 16'hFFFF, 4'd2);
    wait_wb(0);
    chk("rmul_lo", 0, wb_data[0], 16'h0001);
    step();
    wb_ready[0] = 1'b0;
    chk("rmul_hi", 0, wb_hi[0], 1'b1);
    chk("rmul_hi_data", 0, wb_data[0], 16'hFFFE);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rmul_valid", 0, wb_valid[0], 1'b0);
    chk("rmul_ready", 0, req_ready[0], 1'b1);
    chk("rmul_count", 0, op_count[0], 16'h0);
    wb_ready[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("rmul_no_hi", 0, wb_valid[0], 1'b0);
      step();
    end

    // Randomized traffic on both instances.
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < NI; i++) begin
        pend[i] = req_valid[i] && req_ready[i];
        wb_ready[i] = ($urandom_range(0, 9) < 7);
      end
      rst = ($urandom_range(0, 499) != 0);
      step();
      for (int i = 0; i < NI; i++) begin
        if (pend[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          req_op[i]  = 4'($urandom_range(0, 15));
          req_a[i]   = 16'($urandom);
          req_b[i]   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
          req_tag[i] = 4'($urandom);
        end
      end
    end
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      req_valid[i] = 1'b0;
      wb_ready[i] = 1'b1;
    end
    for (int k = 0; k < 10; k++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
